count_capture_unit: RTL and testbench
=====================================

Name: count_capture_unit

Overview:
- Sits directly downstream of the free-running 32-bit counter and consumes its count value.
- Timestamps trigger events: it snapshots the count on each rising edge of trig_in into a small FIFO.
- The FIFO is drained by a consumer over a valid/ready handshake.
- Also flags compare-match and counter wrap/restart events as single-cycle pulses.

Parameters:
- WIDTH, 32, width of count_in and out_data.
- DEPTH, 4, capture FIFO entries; power of 2, minimum 2.
- AW, $clog2(DEPTH), FIFO pointer width; derived, not overridden.

Ports:
- clk  input  1  sole clock; all logic on the rising edge.
- resetn  input  1  reset, synchronous and active-low.
- count_in  input  WIDTH  counter value from the upstream counter.
- trig_in  input  1  event input, synchronous to clk; rising edge triggers a capture.
- cmp_val  input  WIDTH  compare value, quasi-static.
- clr_ovf  input  1  one-cycle pulse that clears the sticky overflow flag.
- out_data  output  WIDTH  head-of-FIFO captured count.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts out_data when out_valid && out_ready.
- level  output  AW+1  current FIFO occupancy, 0..DEPTH.
- overflow  output  1  sticky: a capture was dropped.
- cmp_hit  output  1  one-cycle pulse on count match.
- wrap  output  1  one-cycle pulse on count decrease.

Behaviour:
- Reset, when resetn is sampled low at a clock edge:
  - out_valid=0, level=0, overflow=0, cmp_hit=0, wrap=0, out_data=0.
  - Internal trig_d=0, cnt_d=0, FIFO pointers=0.
  - Reset mid-operation discards all FIFO contents; no partial pop.
- Edge detect:
  - push = trig_in && !trig_d, where trig_d is trig_in registered.
  - trig_in held high produces exactly one capture.
- Capture latency:
  - count_in sampled in the same cycle push is high is written at that clock edge.
  - If the FIFO was empty, out_valid=1 and out_data=captured value in the next cycle (1-cycle latency).
  - No combinational bypass from count_in to out_data.
- Pop:
  - pop = out_valid && out_ready.
  - The head advances at the clock edge; out_data is the registered head entry.
  - out_data is stable while out_valid=1 and out_ready=0.
- Push/pop combinations:
  - Not full, push only: level+1.
  - Pop only: level-1.
  - Push and pop same cycle: level unchanged. This is allowed when full; the push is accepted.
  - Empty: pop is impossible because out_valid=0.
- Overflow:
  - push && full && !pop drops the sample and sets overflow=1 next cycle.
  - overflow stays set until clr_ovf=1 or reset.
  - If clr_ovf and a new drop happen in the same cycle, the set wins.
- Pointers:
  - AW-bit read/write pointers wrap modulo DEPTH.
  - full/empty derive from level.
- Compare:
  - cnt_d = count_in registered.
  - cmp_hit registered: goes high the cycle after count_in==cmp_val && cnt_d!=cmp_val.
  - A count held constant at cmp_val pulses only once.
- Wrap:
  - wrap registered: goes high the cycle after count_in < cnt_d (unsigned).
  - Covers both rollover and upstream counter reset.
  - Suppressed for the first cycle after resetn deasserts.
- Widths:
  - All comparisons unsigned, WIDTH bits.
  - level is AW+1 bits so that DEPTH is representable.

Decomposition:
- Shared package: CNT_WIDTH=32 constant and default DEPTH.
- The counter and this block both import CNT_WIDTH.
- One sub-module, cc_sync_fifo:
  - Parameterised WIDTH/DEPTH.
  - Ports: push, pop, wdata, rdata, level, full, empty.
  - Same clk/resetn convention.
- The top level holds edge detect, overflow, compare and wrap logic.

Test Plan:
- Reset: resetn=0 for 2 cycles with trig_in toggling -> out_valid=0, level=0, overflow=0, no cmp_hit/wrap pulses; after release, no wrap pulse in the first cycle.
- Single capture:
  - count_in=100 at the trig_in rising cycle, out_ready=0 -> next cycle out_valid=1, out_data=100, level=1.
  - Hold 3 cycles -> out_data stays 100.
  - Raise out_ready -> out_valid=0 next cycle.
  - trig_in held high 5 cycles -> exactly 1 capture.
- Fill and overflow: out_ready=0, 5 trigger edges at counts 10,20,30,40,50 -> level=4, overflow=1, entries drained in order 10,20,30,40 (50 lost); clr_ovf pulse -> overflow=0.
- Full with simultaneous push/pop: FIFO full [10,20,30,40], trigger at count 60 with out_ready=1 -> level stays 4, overflow=0, drain order 20,30,40,60.
- Compare and wrap:
  - cmp_val=7, counter runs 0..12 -> single cmp_hit one cycle after count_in=7.
  - Upstream counter reset from 12 to 0 -> single wrap pulse.
  - Counter held at 7 for 4 cycles -> one cmp_hit only.
- Reset mid-operation: level=3, assert resetn=0 for 1 cycle -> level=0, out_valid=0 next cycle; a subsequent capture of count 5 appears as out_data=5.

Source files
------------

// File: rtl/count_capture_unit_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : count_capture_unit_pkg
// Purpose  : Shared constants for the free-running counter and the
//            count_capture_unit that timestamps events from it.
// Contents : CNT_WIDTH     - width of the counter value bus
//            DEFAULT_DEPTH - default capture FIFO depth
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package count_capture_unit_pkg;

  localparam int CNT_WIDTH     = 32;
  localparam int DEFAULT_DEPTH = 4;

endpackage : count_capture_unit_pkg
`default_nettype wire

// File: rtl/count_capture_unit_sync_fifo.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : cc_sync_fifo
// Purpose  : Small single-clock FIFO holding captured count values.
//            A push into a full FIFO is accepted when a pop happens in
//            the same cycle; otherwise it is ignored (the caller flags it).
// Ports    : clk, resetn  - clock, synchronous active-low reset
//            push, wdata  - write request and data
//            pop          - read request (ignored when empty)
//            rdata        - head entry, zero while empty
//            level        - occupancy 0..DEPTH
//            full, empty  - status derived from level
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module cc_sync_fifo
  import count_capture_unit_pkg::*;
#(
  parameter  int WIDTH = CNT_WIDTH,
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty
);

  localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_level;

  logic w_full;
  logic w_empty;
  logic w_wr;
  logic w_rd;

  assign w_full  = (r_level == c_depth);
  assign w_empty = (r_level == '0);
  assign w_rd    = pop && !w_empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign w_wr    = push && (!w_full || w_rd);

  // Storage carries no reset; validity is tracked by r_level alone.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      if (w_wr) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_rd) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Head is read straight from registered storage; forced to zero when
  // empty so the output never shows stale or uninitialised data.
  assign rdata = w_empty ? '0 : r_mem[r_rptr];
  assign level = r_level;
  assign full  = w_full;
  assign empty = w_empty;

endmodule : cc_sync_fifo
`default_nettype wire

// File: rtl/count_capture_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : count_capture_unit
// Purpose  : Timestamps rising edges of trig_in with the upstream counter
//            value into a FIFO drained over valid/ready; also pulses on
//            compare match and on counter wrap/restart.
// Ports    : clk, resetn        - clock, synchronous active-low reset
//            count_in           - counter value
//            trig_in            - event input, rising edge captures
//            cmp_val            - compare value (quasi-static)
//            clr_ovf            - clears the sticky overflow flag
//            out_data/out_valid/out_ready - capture stream
//            level              - FIFO occupancy
//            overflow           - sticky, a capture was dropped
//            cmp_hit, wrap      - single-cycle event pulses
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module count_capture_unit
  import count_capture_unit_pkg::*;
#(
  parameter  int WIDTH = CNT_WIDTH,
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] count_in,
  input  logic             trig_in,
  input  logic [WIDTH-1:0] cmp_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW:0]      level,
  output logic             overflow,
  output logic             cmp_hit,
  output logic             wrap
);

  logic             r_trig_d;
  logic [WIDTH-1:0] r_cnt_d;
  logic             r_overflow;
  logic             r_cmp_hit;
  logic             r_wrap;

  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             w_drop;

  assign w_push = trig_in && !r_trig_d;
  assign w_pop  = out_valid && out_ready;
  // A pop in the same cycle frees a slot, so only a push without a pop
  // into a full FIFO loses its sample.
  assign w_drop = w_push && w_full && !w_pop;

  cc_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (w_push),
    .pop    (w_pop),
    .wdata  (count_in),
    .rdata  (out_data),
    .level  (level),
    .full   (w_full),
    .empty  (w_empty)
  );

  assign out_valid = !w_empty;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_trig_d   <= 1'b0;
      r_cnt_d    <= '0;
      r_overflow <= 1'b0;
      r_cmp_hit  <= 1'b0;
      r_wrap     <= 1'b0;
    end else begin
      r_trig_d <= trig_in;
      r_cnt_d  <= count_in;

      // Set has priority over clear so a drop is never missed.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_ovf) begin
        r_overflow <= 1'b0;
      end

      // Only the arrival at cmp_val pulses; holding the value does not.
      r_cmp_hit <= (count_in == cmp_val) && (r_cnt_d != cmp_val);

      // r_cnt_d is zero straight after reset, so no unsigned value can be
      // below it: the first cycle after release never reports a wrap.
      r_wrap <= (count_in < r_cnt_d);
    end
  end

  assign overflow = r_overflow;
  assign cmp_hit  = r_cmp_hit;
  assign wrap     = r_wrap;

endmodule : count_capture_unit
`default_nettype wire

// File: tb/tb_count_capture_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_count_capture_unit
// Purpose  : Self-checking bench for count_capture_unit. Directed scenario
//            tasks plus a randomized run compared against a queue-based
//            behavioural model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_count_capture_unit;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             resetn;
  logic [WIDTH-1:0] count_in;
  logic             trig_in;
  logic [WIDTH-1:0] cmp_val;
  logic             clr_ovf;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       level;
  logic             overflow;
  logic             cmp_hit;
  logic             wrap;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [WIDTH-1:0] m_q[$];
  logic             m_trig_d;
  logic [WIDTH-1:0] m_cnt_d;
  logic             m_ovf;
  logic             m_cmp;
  logic             m_wrap;

  always #5 clk = ~clk;

  count_capture_unit #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .count_in  (count_in),
    .trig_in   (trig_in),
    .cmp_val   (cmp_val),
    .clr_ovf   (clr_ovf),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .overflow  (overflow),
    .cmp_hit   (cmp_hit),
    .wrap      (wrap)
  );

  // Advance the model by one clock using the inputs currently driven,
  // then step past the DUT's clock edge.
  task automatic tick();
    bit push, pop, drop;
    if (!resetn) begin
      m_q.delete();
      m_trig_d = 1'b0;
      m_cnt_d  = '0;
      m_ovf    = 1'b0;
      m_cmp    = 1'b0;
      m_wrap   = 1'b0;
    end else begin
      push = trig_in && !m_trig_d;
      pop  = (m_q.size() != 0) && out_ready;
      drop = 1'b0;
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (m_q.size() < DEPTH) m_q.push_back(count_in);
        else drop = 1'b1;
      end
      if (clr_ovf) m_ovf = 1'b0;
      if (drop)    m_ovf = 1'b1;
      m_cmp    = (count_in == cmp_val) && (m_cnt_d != cmp_val);
      m_wrap   = count_in < m_cnt_d;
      m_cnt_d  = count_in;
      m_trig_d = trig_in;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_trig(input logic [WIDTH-1:0] c);
    count_in = c;
    trig_in  = 1'b1;
    tick();
    trig_in  = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      trig_in  = ~trig_in;
      count_in = $urandom;
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
      total++; if (level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b exp=0", overflow); end
      total++; if (cmp_hit !== 1'b0) begin bad++; $display("FAIL reset_cmp got=%0b exp=0", cmp_hit); end
      total++; if (wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap got=%0b exp=0", wrap); end
    end
    resetn   = 1'b1;
    trig_in  = 1'b0;
    count_in = $urandom;
    tick();
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL release_wrap got=%0b exp=0", wrap); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL release_valid got=%0b exp=0", out_valid); end
    count_in = 0;
    tick();
  endtask

  task automatic test_single_capture();
    out_ready = 1'b0;
    count_in  = 100;
    trig_in   = 1'b1;
    tick();
    trig_in   = 1'b0;
    count_in  = 101;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0b exp=1", out_valid); end
    total++; if (out_data !== 100) begin bad++; $display("FAIL single_data got=%0d exp=100", out_data); end
    total++; if (level !== 3'd1) begin bad++; $display("FAIL single_level got=%0d exp=1", level); end
    for (int i = 0; i < 3; i++) begin
      count_in = 102 + i;
      tick();
      total++; if (out_data !== 100) begin bad++; $display("FAIL single_hold got=%0d exp=100", out_data); end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_pop got=%0b exp=0", out_valid); end
    trig_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      count_in = 200 + i;
      tick();
    end
    trig_in = 1'b0;
    tick();
    total++; if (level !== 3'd1) begin bad++; $display("FAIL held_trig_level got=%0d exp=1", level); end
    total++; if (out_data !== 200) begin bad++; $display("FAIL held_trig_data got=%0d exp=200", out_data); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_fill_overflow();
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) pulse_trig(10 * k);
    total++; if (level !== 3'd4) begin bad++; $display("FAIL fill_level got=%0d exp=4", level); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL fill_ovf got=%0b exp=1", overflow); end
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      total++; if (out_data !== 10 * k) begin bad++; $display("FAIL fill_drain got=%0d exp=%0d", out_data, 10 * k); end
      tick();
    end
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fill_empty got=%0b exp=0", out_valid); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0b exp=1", overflow); end
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%0b exp=0", overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [WIDTH-1:0] exp_order [4];
    exp_order[0] = 20; exp_order[1] = 30; exp_order[2] = 40; exp_order[3] = 60;
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) pulse_trig(10 * k);
    total++; if (level !== 3'd4) begin bad++; $display("FAIL full_level got=%0d exp=4", level); end
    count_in  = 60;
    trig_in   = 1'b1;
    out_ready = 1'b1;
    tick();
    trig_in   = 1'b0;
    out_ready = 1'b0;
    total++; if (level !== 3'd4) begin bad++; $display("FAIL pushpop_level got=%0d exp=4", level); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL pushpop_ovf got=%0b exp=0", overflow); end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      total++; if (out_data !== exp_order[k]) begin bad++; $display("FAIL pushpop_drain got=%0d exp=%0d", out_data, exp_order[k]); end
      tick();
    end
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL pushpop_empty got=%0b exp=0", out_valid); end
  endtask

  task automatic test_compare_wrap();
    int hits;
    cmp_val  = 7;
    count_in = 0;
    tick();
    tick();
    for (int c = 0; c <= 12; c++) begin
      count_in = c;
      tick();
      total++; if (cmp_hit !== (c == 8 - 1)) begin bad++; $display("FAIL cmp_run c=%0d got=%0b exp=%0b", c, cmp_hit, c == 7); end
      total++; if (wrap !== 1'b0) begin bad++; $display("FAIL wrap_run c=%0d got=%0b exp=0", c, wrap); end
    end
    count_in = 0;
    tick();
    total++; if (wrap !== 1'b1) begin bad++; $display("FAIL wrap_restart got=%0b exp=1", wrap); end
    tick();
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL wrap_single got=%0b exp=0", wrap); end
    hits = 0;
    count_in = 7;
    for (int i = 0; i < 4; i++) begin
      tick();
      hits += int'(cmp_hit);
    end
    count_in = 0;
    tick();
    hits += int'(cmp_hit);
    total++; if (hits !== 1) begin bad++; $display("FAIL cmp_hold got=%0d exp=1", hits); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) pulse_trig(k);
    total++; if (level !== 3'd3) begin bad++; $display("FAIL mid_prefill got=%0d exp=3", level); end
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    total++; if (level !== 3'd0) begin bad++; $display("FAIL mid_level got=%0d exp=0", level); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%0b exp=0", out_valid); end
    count_in = 5;
    trig_in  = 1'b1;
    tick();
    trig_in  = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_recap_valid got=%0b exp=1", out_valid); end
    total++; if (out_data !== 5) begin bad++; $display("FAIL mid_recap_data got=%0d exp=5", out_data); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic             exp_valid;
    logic [2:0]       exp_level;
    resetn = 1'b0;
    tick();
    resetn  = 1'b1;
    cmp_val = $urandom_range(0, 15);
    for (int i = 0; i < 400; i++) begin
      resetn    = ($urandom_range(0, 79) != 0);
      trig_in   = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) == 0);
      clr_ovf   = ($urandom_range(0, 7) == 0);
      count_in  = $urandom_range(0, 15);
      tick();
      exp_valid = (m_q.size() != 0);
      exp_level = 3'(m_q.size());
      total++; if (out_valid !== exp_valid) begin bad++; $display("FAIL rnd_valid i=%0d got=%0b exp=%0b", i, out_valid, exp_valid); end
      if (exp_valid) begin
        total++; if (out_data !== m_q[0]) begin bad++; $display("FAIL rnd_data i=%0d got=%0d exp=%0d", i, out_data, m_q[0]); end
      end
      total++; if (level !== exp_level) begin bad++; $display("FAIL rnd_level i=%0d got=%0d exp=%0d", i, level, exp_level); end
      total++; if (overflow !== m_ovf) begin bad++; $display("FAIL rnd_ovf i=%0d got=%0b exp=%0b", i, overflow, m_ovf); end
      total++; if (cmp_hit !== m_cmp) begin bad++; $display("FAIL rnd_cmp i=%0d got=%0b exp=%0b", i, cmp_hit, m_cmp); end
      total++; if (wrap !== m_wrap) begin bad++; $display("FAIL rnd_wrap i=%0d got=%0b exp=%0b", i, wrap, m_wrap); end
    end
    resetn    = 1'b1;
    trig_in   = 1'b0;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;
  endtask

  initial begin
    resetn    = 1'b0;
    count_in  = '0;
    trig_in   = 1'b0;
    cmp_val   = 32'hFFFF_FFFF;
    clr_ovf   = 1'b0;
    out_ready = 1'b0;
    m_trig_d  = 1'b0;
    m_cnt_d   = '0;
    m_ovf     = 1'b0;
    m_cmp     = 1'b0;
    m_wrap    = 1'b0;
    #2;
    test_reset();
    test_single_capture();
    test_fill_overflow();
    test_full_push_pop();
    test_compare_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_count_capture_unit
`default_nettype wire
